// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA bit-serial datapath blocks.
package rsa_pkg;

  localparam int RSA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SHIFT,
    SER_DONE
  } ser_state_t;

endpackage

// File: rtl/rsa_bit_counter.sv
// Bit-index up-counter with clear/enable and a terminal-index flag; also usable
// as the iteration counter of the multiplier loop.
module rsa_bit_counter
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_DEFAULT_WIDTH,
  parameter int CNTW  = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            clr,
  input  logic            inc,
  output logic [CNTW-1:0] cnt,
  output logic            is_last
);

  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNTW'(1);
    end
  end

  assign is_last = (cnt == LAST_IDX);

endmodule

// File: rtl/rsa_operand_serializer.sv
// Loads a parallel operand and presents it one bit per accepted transfer,
// LSB first, flagging the last bit and completion for the multiplier control.
module rsa_operand_serializer
  import rsa_pkg::*;
#(
  parameter int   WIDTH = RSA_DEFAULT_WIDTH,
  localparam int  CNTW  = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             load,
  input  logic [WIDTH-1:0] operand,
  input  logic             bit_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [CNTW-1:0]  bit_idx,
  output logic             last,
  output logic             busy,
  output logic             done
);

  ser_state_t       state;
  ser_state_t       state_n;
  logic [WIDTH-1:0] shreg;
  logic [CNTW-1:0]  cnt;
  logic             is_last;
  logic             ld;
  logic             xfer;

  // Terminal transfer clears the counter so it never wraps past WIDTH-1.
  rsa_bit_counter #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_cnt (
    .clk     (clk),
    .rstb    (rstb),
    .clr     (ld | (xfer & is_last)),
    .inc     (xfer & ~is_last),
    .cnt     (cnt),
    .is_last (is_last)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= SER_IDLE;
      shreg <= '0;
    end else begin
      state <= state_n;
      if (ld) begin
        shreg <= operand;
      end else if (xfer) begin
        shreg <= shreg >> 1;
      end
    end
  end

  // A load while shifting restarts the operand and is never a transfer.
  always_comb begin
    state_n = state;
    ld      = 1'b0;
    xfer    = 1'b0;
    if (ena) begin
      case (state)
        SER_IDLE: begin
          if (load) begin
            ld      = 1'b1;
            state_n = SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (load) begin
            ld = 1'b1;
          end else if (bit_ready) begin
            xfer = 1'b1;
            if (is_last) begin
              state_n = SER_DONE;
            end
          end
        end
        SER_DONE: begin
          ld      = load;
          state_n = load ? SER_SHIFT : SER_IDLE;
        end
        default: state_n = SER_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_valid = (state == SER_SHIFT);
    busy      = (state == SER_SHIFT);
    done      = (state == SER_DONE);
    bit_out   = bit_valid & shreg[0];
    bit_idx   = bit_valid ? cnt : '0;
    last      = bit_valid & is_last;
  end

endmodule
